sdc_init_seq: RTL and testbench
===============================

// Module: sdc_init_seq
// PURPOSE
//  SD-card SPI-mode initialisation sequencer; sits directly upstream of the SPI command engine (SPI_cmd_sdc).
//  On i_start it issues CMD0, CMD8, (CMD55+ACMD41)*, [CMD16] through the engine's i_we/i_cmd/i_arg/i_crc port.
//  Each R1 byte returned on the engine's o_res/o_done is checked. The sequencer reports ready, card version or an error code.
// PARAMETERS
//  PWR_WAIT     200000  clocks to wait after i_start before CMD0 (card power-up; engine keeps CS high)
//  CMD0_RETRY   8       max CMD0 attempts before error
//  ACMD_RETRY   1000    max CMD55+ACMD41 pairs before error
//  RETRY_GAP    5000    idle clocks between ACMD41 attempts
//  RESP_TIMEOUT 100000  max clocks from o_we to i_done before error
// PORTS
//  i_clk        in   1   system clock, all logic on rising edge
//  i_rst_n      in   1   synchronous reset, active low
//  i_start      in   1   1-cycle pulse: begin (or restart) initialisation
//  o_cmd        out  8   command byte to engine (0x40|index)
//  o_arg        out  32  command argument to engine
//  o_crc        out  8   CRC7+stop byte to engine
//  o_we         out  1   1-cycle issue strobe to engine
//  i_done       in   1   engine: R1 valid on i_res this cycle
//  i_res        in   8   engine: R1 response byte
//  o_busy       out  1   sequence in progress
//  o_ready      out  1   card initialised (sticky until restart/reset)
//  o_card_v2    out  1   CMD8 accepted (SD v2, HCS requested)
//  o_error      out  1   sequence failed (sticky until restart/reset)
//  o_err_code   out  3   1 CMD0, 2 CMD8, 3 ACMD41 timeout, 4 CMD16, 5 CMD55, 6 resp timeout
// BEHAVIOUR
//  Reset (i_rst_n=0 at clk edge): state IDLE. Every output 0. Counters cleared. Any sequence in flight is abandoned.
//  States: IDLE, PWR, CMD0, CMD8, CMD55, ACMD41, GAP, CMD16, READY, ERROR.
//  Each command state has two phases:
//   - ISSUE: o_we=1 for exactly one cycle, with o_cmd/o_arg/o_crc valid in that cycle.
//   - WAIT: o_cmd/o_arg/o_crc held stable until i_done.
//  i_done is ignored outside WAIT. An R1 is consumed only on the i_done cycle.
//  Command table:
//   CMD0   40 / 00000000 / 95
//   CMD8   48 / 000001AA / 87
//   CMD55  77 / 00000000 / 65
//   ACMD41 69 / 40000000 (v2) or 00000000 (v1) / 77
//   CMD16  50 / 00000200 / 15
//  IDLE/READY/ERROR + i_start -> PWR. Clear o_ready, o_error, o_err_code, o_card_v2 and counters. o_busy=1 from next cycle.
//  PWR: count PWR_WAIT clocks -> CMD0.
//  CMD0: R1==01 -> CMD8. Otherwise retry; after CMD0_RETRY total attempts -> ERROR code 1.
//  CMD8: R1==01 -> o_card_v2=1, go to CMD55. R1==05 (illegal cmd) -> v1, go to CMD55. Else -> ERROR code 2.
//  CMD55: R1 in {00,01} -> ACMD41. Else -> ERROR code 5.
//  ACMD41: R1==00 -> CMD16 if v1, READY if v2. R1==01 -> increment attempt count.
//   If attempts==ACMD_RETRY -> ERROR code 3, else -> GAP. Other R1 -> ERROR code 3.
//  GAP: count RETRY_GAP clocks -> CMD55.
//  CMD16: R1==00 -> READY. Else -> ERROR code 4.
//  Watchdog: in any WAIT phase, RESP_TIMEOUT clocks without i_done -> ERROR code 6.
//   Counter restarts at each ISSUE.
//  READY: o_ready=1, o_busy=0. ERROR: o_error=1, o_busy=0. Both states hold until i_start or reset.
//  i_start while o_busy=1 is ignored. i_rst_n low overrides i_start in the same cycle.
//  i_done coincident with watchdog expiry: i_done wins.
//  Latency: ISSUE occurs 1 clock after entering a command state. Next state is taken on the clock after i_done.
//  Counter widths: $clog2 of the parameter plus 1. No wrap-around is possible before the limit compare.
// TESTING
//  Use a behavioural engine model that returns a scripted R1 N clocks after o_we; set PWR_WAIT=10, RETRY_GAP=4.
//  1 v2 card: R1 sequence 01,01,01,01,01,00
//    -> o_we issue order 40,48,77,69,77,69; o_card_v2=1; o_ready=1; no CMD16 issued.
//  2 v1 card: CMD8 R1=05, ACMD41 R1=00, CMD16 R1=00
//    -> CMD16 issued with arg 00000200 and ACMD41 arg 0; o_ready=1, o_card_v2=0.
//  3 CMD0 R1=FF forever, CMD0_RETRY=3
//    -> exactly 3 CMD0 strobes, then o_error=1, o_err_code=1, o_busy=0.
//  4 ACMD41 R1=01 forever, ACMD_RETRY=4
//    -> 4 CMD55/ACMD41 pairs, each pair separated by >=4 idle clocks; then o_err_code=3.
//  5 model never asserts i_done after CMD8, RESP_TIMEOUT=50
//    -> o_err_code=6 exactly 50 clocks after the CMD8 o_we.
//  6 assert i_rst_n=0 during ACMD41 WAIT, then i_start
//    -> all outputs 0 on the cycle after reset; restart issues CMD0 after PWR_WAIT; i_start while busy has no effect.

Source files
------------

// File: rtl/sdc_init_seq.sv
// SD-card SPI-mode initialisation sequencer: drives CMD0/CMD8/(CMD55+ACMD41)*/CMD16
// through the SPI command engine and reports ready, card version or an error code.
module sdc_init_seq #(
  parameter int PWR_WAIT     = 200000,
  parameter int CMD0_RETRY   = 8,
  parameter int ACMD_RETRY   = 1000,
  parameter int RETRY_GAP    = 5000,
  parameter int RESP_TIMEOUT = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic [7:0]  o_cmd,
  output logic [31:0] o_arg,
  output logic [7:0]  o_crc,
  output logic        o_we,
  input  logic        i_done,
  input  logic [7:0]  i_res,
  output logic        o_busy,
  output logic        o_ready,
  output logic        o_card_v2,
  output logic        o_error,
  output logic [2:0]  o_err_code
);

  localparam int DLY_MAX = (PWR_WAIT > RETRY_GAP) ? PWR_WAIT : RETRY_GAP;
  localparam int DLY_W   = $clog2(DLY_MAX) + 1;
  localparam int C0_W    = $clog2(CMD0_RETRY) + 1;
  localparam int AC_W    = $clog2(ACMD_RETRY) + 1;
  localparam int WD_W    = $clog2(RESP_TIMEOUT) + 1;

  localparam logic [DLY_W-1:0] PWR_LAST = DLY_W'(PWR_WAIT - 1);
  localparam logic [DLY_W-1:0] GAP_LAST = DLY_W'(RETRY_GAP - 1);
  localparam logic [C0_W-1:0]  C0_LAST  = C0_W'(CMD0_RETRY - 1);
  localparam logic [AC_W-1:0]  AC_LAST  = AC_W'(ACMD_RETRY - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(RESP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_GAP, S_CMD16, S_READY, S_ERROR
  } state_t;

  state_t           state;
  logic             issue;
  logic [DLY_W-1:0] dly_cnt;
  logic [C0_W-1:0]  c0_cnt;
  logic [AC_W-1:0]  ac_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             in_wait;
  logic [2:0]       fail_code;

  function automatic logic [47:0] cmd_frame(input state_t st, input logic v2);
    case (st)
      S_CMD0:   cmd_frame = {8'h40, 32'h0000_0000, 8'h95};
      S_CMD8:   cmd_frame = {8'h48, 32'h0000_01AA, 8'h87};
      S_CMD55:  cmd_frame = {8'h77, 32'h0000_0000, 8'h65};
      S_ACMD41: cmd_frame = {8'h69, (v2 ? 32'h4000_0000 : 32'h0000_0000), 8'h77};
      default:  cmd_frame = {8'h50, 32'h0000_0200, 8'h15};
    endcase
  endfunction

  assign in_wait = !issue &&
                   (state inside {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD16});

  // Response checking; a response arriving on the watchdog's last cycle still counts.
  always_comb begin
    fail_code = 3'd0;
    if (in_wait) begin
      if (i_done) begin
        case (state)
          S_CMD0:   if (i_res != 8'h01 && c0_cnt == C0_LAST) fail_code = 3'd1;
          S_CMD8:   if (i_res != 8'h01 && i_res != 8'h05) fail_code = 3'd2;
          S_CMD55:  if (i_res > 8'h01) fail_code = 3'd5;
          S_ACMD41: begin
            if (i_res == 8'h01) begin
              if (ac_cnt == AC_LAST) fail_code = 3'd3;
            end else if (i_res != 8'h00) begin
              fail_code = 3'd3;
            end
          end
          S_CMD16:  if (i_res != 8'h00) fail_code = 3'd4;
          default:  fail_code = 3'd0;
        endcase
      end else if (wd_cnt == WD_LAST) begin
        fail_code = 3'd6;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      issue      <= 1'b0;
      dly_cnt    <= '0;
      c0_cnt     <= '0;
      ac_cnt     <= '0;
      wd_cnt     <= '0;
      o_cmd      <= 8'h00;
      o_arg      <= 32'h0;
      o_crc      <= 8'h00;
      o_we       <= 1'b0;
      o_busy     <= 1'b0;
      o_ready    <= 1'b0;
      o_card_v2  <= 1'b0;
      o_error    <= 1'b0;
      o_err_code <= 3'd0;
    end else begin
      o_we <= 1'b0;
      case (state)
        S_IDLE, S_READY, S_ERROR: begin
          if (i_start) begin
            state      <= S_PWR;
            o_busy     <= 1'b1;
            o_ready    <= 1'b0;
            o_error    <= 1'b0;
            o_err_code <= 3'd0;
            o_card_v2  <= 1'b0;
            dly_cnt    <= '0;
            c0_cnt     <= '0;
            ac_cnt     <= '0;
            wd_cnt     <= '0;
          end
        end
        S_PWR: begin
          if (dly_cnt == PWR_LAST) begin
            state <= S_CMD0;
            issue <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        S_GAP: begin
          if (dly_cnt == GAP_LAST) begin
            state <= S_CMD55;
            issue <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD16: begin
          if (issue) begin
            issue                 <= 1'b0;
            o_we                  <= 1'b1;
            {o_cmd, o_arg, o_crc} <= cmd_frame(state, o_card_v2);
            wd_cnt                <= '0;
          end else if (fail_code != 3'd0) begin
            state      <= S_ERROR;
            o_error    <= 1'b1;
            o_busy     <= 1'b0;
            o_err_code <= fail_code;
          end else if (i_done) begin
            case (state)
              S_CMD0: begin
                if (i_res == 8'h01) state <= S_CMD8;
                else c0_cnt <= c0_cnt + C0_W'(1);
                issue <= 1'b1;
              end
              S_CMD8: begin
                o_card_v2 <= (i_res == 8'h01);
                state     <= S_CMD55;
                issue     <= 1'b1;
              end
              S_CMD55: begin
                state <= S_ACMD41;
                issue <= 1'b1;
              end
              S_ACMD41: begin
                if (i_res == 8'h00) begin
                  if (o_card_v2) begin
                    state   <= S_READY;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                  end else begin
                    state <= S_CMD16;
                    issue <= 1'b1;
                  end
                end else begin
                  ac_cnt  <= ac_cnt + AC_W'(1);
                  dly_cnt <= '0;
                  state   <= S_GAP;
                end
              end
              default: begin
                state   <= S_READY;
                o_ready <= 1'b1;
                o_busy  <= 1'b0;
              end
            endcase
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_init_seq.sv
// Directed bench for sdc_init_seq: a scripted engine model answers each command
// with a fixed R1 a fixed number of clocks after o_we.
module tb_sdc_init_seq;

  localparam int PWR_WAIT     = 10;
  localparam int CMD0_RETRY   = 3;
  localparam int ACMD_RETRY   = 4;
  localparam int RETRY_GAP    = 4;
  localparam int RESP_TIMEOUT = 50;
  localparam int LAT          = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  res = 8'h00;
  logic [7:0]  cmd, crc;
  logic [31:0] arg;
  logic        we, busy, ready, card_v2, error;
  logic [2:0]  err_code;

  sdc_init_seq #(
    .PWR_WAIT(PWR_WAIT), .CMD0_RETRY(CMD0_RETRY), .ACMD_RETRY(ACMD_RETRY),
    .RETRY_GAP(RETRY_GAP), .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_cmd(cmd), .o_arg(arg), .o_crc(crc), .o_we(we),
    .i_done(done), .i_res(res),
    .o_busy(busy), .o_ready(ready), .o_card_v2(card_v2),
    .o_error(error), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine script, set by the stimulus process
  logic [7:0] r_cmd0, r_cmd8, r_cmd55, r_cmd16, mute_cmd;
  int         acmd_ones;

  logic [7:0]  log_cmd [256];
  logic [31:0] log_arg [256];
  logic [7:0]  log_crc [256];
  int          log_cyc [256];
  int          n_log = 0;
  int          acmd_cnt = 0;

  always begin
    logic [7:0] r;
    @(negedge clk);
    if (we === 1'b1) begin
      if (n_log < 256) begin
        log_cmd[n_log] = cmd;
        log_arg[n_log] = arg;
        log_crc[n_log] = crc;
        log_cyc[n_log] = cyc;
      end
      n_log++;
      if (cmd != mute_cmd) begin
        case (cmd)
          8'h40:   r = r_cmd0;
          8'h48:   r = r_cmd8;
          8'h77:   r = r_cmd55;
          8'h69:   r = (acmd_cnt < acmd_ones) ? 8'h01 : 8'h00;
          default: r = r_cmd16;
        endcase
        if (cmd == 8'h40) acmd_cnt = 0;
        if (cmd == 8'h69) acmd_cnt++;
        repeat (LAT - 1) @(negedge clk);
        done = 1'b1;
        res  = r;
        @(negedge clk);
        done = 1'b0;
        res  = 8'h00;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int base = 0;
  int st_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] cmd_at(input int i);
    return log_cmd[base + i];
  endfunction

  task automatic script(input logic [7:0] c0, input logic [7:0] c8, input logic [7:0] c55,
                        input int ones, input logic [7:0] c16, input logic [7:0] mute);
    r_cmd0 = c0; r_cmd8 = c8; r_cmd55 = c55; acmd_ones = ones; r_cmd16 = c16; mute_cmd = mute;
  endtask

  task automatic start_seq(input string tag);
    @(negedge clk);
    base  = n_log;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    st_cyc = cyc;
    check({tag, "_start"}, {60'd0, busy, ready, error, card_v2}, 64'h8);
    check({tag, "_code_clr"}, {61'd0, err_code}, 64'd0);
  endtask

  task automatic wait_end(input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (ready || error) break;
    end
    check({tag, "_end_seen"}, {63'd0, (k < 3000)}, 64'd1);
  endtask

  task automatic wait_log(input int n, input string tag);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (n_log >= base + n) break;
      @(negedge clk);
    end
    check({tag, "_log_seen"}, {63'd0, (k < 3000)}, 64'd1);
  endtask

  initial begin
    script(8'h01, 8'h01, 8'h01, 0, 8'h00, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", {8'd0, busy, ready, error, err_code, card_v2, we, cmd, arg, crc}, 64'd0);
    rst_n = 1'b1;

    // 1: v2 card, one ACMD41 retry
    script(8'h01, 8'h01, 8'h01, 1, 8'h00, 8'h00);
    start_seq("v2");
    wait_end("v2");
    repeat (10) @(negedge clk);
    check("v2_nlog", n_log - base, 6);
    check("v2_order", {16'd0, cmd_at(0), cmd_at(1), cmd_at(2), cmd_at(3), cmd_at(4), cmd_at(5)},
          64'h0000_4048_7769_7769);
    check("v2_pwr_lat", log_cyc[base] - st_cyc, PWR_WAIT + 1);
    check("v2_cmd8_frame", {16'd0, log_cmd[base+1], log_arg[base+1], log_crc[base+1]}, 64'h48_0000_01AA_87);
    check("v2_acmd_arg", {32'd0, log_arg[base+3]}, 64'h4000_0000);
    check("v2_gap", log_cyc[base+4] - log_cyc[base+3], LAT + RETRY_GAP + 1);
    check("v2_flags", {60'd0, busy, ready, error, card_v2}, 64'h5);

    // 2: v1 card, CMD16 required
    script(8'h01, 8'h05, 8'h01, 0, 8'h00, 8'h00);
    start_seq("v1");
    wait_end("v1");
    check("v1_nlog", n_log - base, 5);
    check("v1_acmd_frame", {16'd0, log_cmd[base+3], log_arg[base+3], log_crc[base+3]}, 64'h69_0000_0000_77);
    check("v1_cmd16_frame", {16'd0, log_cmd[base+4], log_arg[base+4], log_crc[base+4]}, 64'h50_0000_0200_15);
    check("v1_flags", {60'd0, busy, ready, error, card_v2}, 64'h4);

    // 3: CMD0 never answered with 01
    script(8'hFF, 8'h01, 8'h01, 0, 8'h00, 8'h00);
    start_seq("c0");
    wait_end("c0");
    repeat (5) @(negedge clk);
    check("c0_nlog", n_log - base, CMD0_RETRY);
    check("c0_all_cmd0", {40'd0, cmd_at(0), cmd_at(1), cmd_at(2)}, 64'h40_4040);
    check("c0_flags", {57'd0, busy, ready, error, err_code, card_v2}, {57'd0, 7'b0010010});

    // 4: ACMD41 stays idle forever
    script(8'h01, 8'h01, 8'h01, 1000, 8'h00, 8'h00);
    start_seq("ac");
    wait_end("ac");
    repeat (5) @(negedge clk);
    check("ac_nlog", n_log - base, 2 + 2 * ACMD_RETRY);
    check("ac_last_pair", {48'd0, cmd_at(8), cmd_at(9)}, 64'h7769);
    for (int p = 0; p < ACMD_RETRY - 1; p++)
      check("ac_gap", log_cyc[base + 4 + 2 * p] - log_cyc[base + 3 + 2 * p], LAT + RETRY_GAP + 1);
    check("ac_code", {60'd0, error, err_code}, 64'hB);

    // 5: no response to CMD8 -> watchdog
    script(8'h01, 8'h01, 8'h01, 0, 8'h00, 8'h48);
    start_seq("wd");
    wait_log(2, "wd");
    begin
      int lim;
      lim = 0;
      while (cyc < log_cyc[base + 1] + RESP_TIMEOUT - 1 && lim < 200) begin
        @(negedge clk);
        lim++;
      end
      check("wd_before", {60'd0, error, err_code}, 64'h0);
      @(negedge clk);
      check("wd_after", {59'd0, busy, error, err_code}, 64'hE);
    end

    // CMD8 garbage -> code 2; CMD55 garbage -> code 5
    script(8'h01, 8'hFF, 8'h01, 0, 8'h00, 8'h00);
    start_seq("c8");
    wait_end("c8");
    check("c8_code", {60'd0, error, err_code}, 64'hA);
    script(8'h01, 8'h05, 8'h04, 0, 8'h00, 8'h00);
    start_seq("c55");
    wait_end("c55");
    check("c55_code", {60'd0, error, err_code}, 64'hD);

    // 6: reset during ACMD41 wait, restart, and a start pulse while busy
    script(8'h01, 8'h01, 8'h01, 0, 8'h00, 8'h69);
    start_seq("rs");
    wait_log(4, "rs");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rs_outs", {8'd0, busy, ready, error, err_code, card_v2, we, cmd, arg, crc}, 64'd0);
    rst_n    = 1'b1;
    mute_cmd = 8'h00;
    start_seq("rs2");
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("rs2");
    check("rs2_pwr_lat", log_cyc[base] - st_cyc, PWR_WAIT + 1);
    check("rs2_first", {56'd0, cmd_at(0)}, 64'h40);
    check("rs2_nlog", n_log - base, 4);
    check("rs2_flags", {60'd0, busy, ready, error, card_v2}, 64'h5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
